// File: rtl/qif_mon_pkg.sv
// -----------------------------------------------------------------------------
// qif_mon_pkg
// Shared types and default sizing for the QIF spike monitor.
//   mon_state_e   : burst-detector state (IDLE / TRACK / BURST)
//   *_DEF         : default widths and burst thresholds used by the top level
// -----------------------------------------------------------------------------
package qif_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    BURST = 2'd2
  } mon_state_e;

  localparam int WIN_W_DEF     = 16;
  localparam int CNT_W_DEF     = 8;
  localparam int ISI_W_DEF     = 12;
  localparam int BURST_ISI_DEF = 8;
  localparam int BURST_N_DEF   = 3;

endpackage

// File: rtl/qif_sat_counter.sv
// -----------------------------------------------------------------------------
// qif_sat_counter
// Up-counter that stops at MAXV. Priority: clear > load > increment.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (count -> 0)
//   clr_i         : synchronous clear
//   load_i        : synchronous load of load_val_i
//   load_val_i    : value loaded when load_i is high
//   inc_i         : increment enable (no effect once at MAXV)
//   cnt_o         : current count
// -----------------------------------------------------------------------------
module qif_sat_counter #(
  parameter int           W    = 8,
  parameter logic [W-1:0] MAXV = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != MAXV)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/qif_spike_monitor.sv
// -----------------------------------------------------------------------------
// qif_spike_monitor
// Turns the QIF neuron's spike level into a windowed firing rate, a per-spike
// inter-spike interval and a burst flag. Only rising edges of spike_in count.
// Optional build macro: QIF_MON_MINMAX_EN adds running ISI min/max outputs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   spike_in    : neuron spike level (may be high for several cycles)
//   window_len  : rate window length in cycles (0 behaves as 1), sampled at
//                 the start of every window
//   rate_out    : spike count of the last completed window (saturating)
//   rate_valid  : one-cycle pulse when rate_out updates
//   isi_out     : last inter-spike interval in cycles (saturating)
//   isi_valid   : one-cycle pulse when isi_out updates
//   isi_min/max : (QIF_MON_MINMAX_EN only) running min / max of isi_out
//   burst_flag  : high while the burst detector is in BURST
// -----------------------------------------------------------------------------
module qif_spike_monitor
  import qif_mon_pkg::*;
#(
  parameter int WIN_W     = WIN_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ISI_W     = ISI_W_DEF,
  parameter int BURST_ISI = BURST_ISI_DEF,
  parameter int BURST_N   = BURST_N_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid,
`ifdef QIF_MON_MINMAX_EN
  output logic [ISI_W-1:0] isi_min,
  output logic [ISI_W-1:0] isi_max,
`endif
  output logic             burst_flag
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_MAX   = {ISI_W{1'b1}};
  localparam int               SC_W      = $clog2(BURST_N + 1);
  localparam logic [SC_W-1:0]  SC_MAX    = SC_W'(BURST_N);
  localparam logic [SC_W-1:0]  SC_ENTER  = SC_W'(BURST_N - 1);
  localparam logic [ISI_W-1:0] SHORT_LIM = ISI_W'(BURST_ISI);

  function automatic logic [WIN_W-1:0] norm_len(input logic [WIN_W-1:0] len);
    return (len == '0) ? WIN_W'(1) : len;
  endfunction

  logic             spike_d_q;
  logic             event_q;
  logic             first_q;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] wcnt_q;
  logic [WIN_W-1:0] wcnt_d;
  logic [WIN_W-1:0] win_now;
  logic             win_close;
  logic [CNT_W-1:0] scnt_q;
  logic [CNT_W-1:0] rate_d;
  logic [ISI_W-1:0] icnt_q;
  logic [SC_W-1:0]  shortcnt_q;
  logic             sc_clr;
  logic             sc_inc;
  logic             isi_upd;
  mon_state_e       state_q;
  mon_state_e       state_d;

  logic [CNT_W-1:0] rate_out_q;
  logic             rate_valid_q;
  logic [ISI_W-1:0] isi_out_q;
  logic             isi_valid_q;
  logic             burst_flag_q;

  // The first cycle after reset has no latched length yet, so the live
  // window_len is used directly for that window.
  always_comb begin
    win_now   = first_q ? norm_len(window_len) : win_len_q;
    win_close = (wcnt_q == (win_now - WIN_W'(1)));
    wcnt_d    = win_close ? '0 : (wcnt_q + WIN_W'(1));
    rate_d    = (event_q && (scnt_q != CNT_MAX)) ? (scnt_q + CNT_W'(1)) : scnt_q;
  end

  // Clear beats increment, so an event on the closing cycle is folded into
  // rate_d instead of leaking into the next window.
  qif_sat_counter #(.W(CNT_W), .MAXV(CNT_MAX)) u_scnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (win_close),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .inc_i      (event_q),
    .cnt_o      (scnt_q)
  );

  // Restarts at 1 on each event so the value seen at the next event equals
  // the distance between the two events.
  qif_sat_counter #(.W(ISI_W), .MAXV(ISI_MAX)) u_icnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (1'b0),
    .load_i     (event_q),
    .load_val_i (ISI_W'(1)),
    .inc_i      (1'b1),
    .cnt_o      (icnt_q)
  );

  qif_sat_counter #(.W(SC_W), .MAXV(SC_MAX)) u_shortcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (sc_clr),
    .load_i     (1'b0),
    .load_val_i ({SC_W{1'b0}}),
    .inc_i      (sc_inc),
    .cnt_o      (shortcnt_q)
  );

  // Burst detector next-state. An event is checked before the timeout so a
  // coincident event decides the transition with its own ISI.
  always_comb begin
    state_d = state_q;
    sc_clr  = 1'b0;
    sc_inc  = 1'b0;
    isi_upd = event_q && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (event_q) state_d = TRACK;
      end
      TRACK: begin
        if (event_q) begin
          if (icnt_q < SHORT_LIM) begin
            sc_inc = 1'b1;
            if (shortcnt_q >= SC_ENTER) state_d = BURST;
          end else begin
            sc_clr = 1'b1;
          end
        end
      end
      BURST: begin
        if (event_q) begin
          if (icnt_q < SHORT_LIM) begin
            sc_inc = 1'b1;
          end else begin
            sc_clr  = 1'b1;
            state_d = TRACK;
          end
        end else if (icnt_q == SHORT_LIM) begin
          sc_clr  = 1'b1;
          state_d = TRACK;
        end
      end
      default: begin
        sc_clr  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      burst_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_flag_q <= (state_d == BURST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_d_q    <= 1'b0;
      event_q      <= 1'b0;
      first_q      <= 1'b1;
      win_len_q    <= '0;
      wcnt_q       <= '0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      isi_out_q    <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      spike_d_q    <= spike_in;
      event_q      <= spike_in & ~spike_d_q;
      first_q      <= 1'b0;
      if (first_q || win_close) win_len_q <= norm_len(window_len);
      wcnt_q       <= wcnt_d;
      rate_valid_q <= win_close;
      if (win_close) rate_out_q <= rate_d;
      isi_valid_q  <= isi_upd;
      if (isi_upd) isi_out_q <= icnt_q;
    end
  end

`ifdef QIF_MON_MINMAX_EN
  logic [ISI_W-1:0] isi_min_q;
  logic [ISI_W-1:0] isi_max_q;

  // A saturated ISI is only a lower bound on the true interval, so it may
  // raise the maximum but must not pull the minimum down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_min_q <= ISI_MAX;
      isi_max_q <= '0;
    end else if (isi_upd) begin
      if ((icnt_q != ISI_MAX) && (icnt_q < isi_min_q)) isi_min_q <= icnt_q;
      if (icnt_q > isi_max_q) isi_max_q <= icnt_q;
    end
  end

  assign isi_min = isi_min_q;
  assign isi_max = isi_max_q;
`endif

  assign rate_out   = rate_out_q;
  assign rate_valid = rate_valid_q;
  assign isi_out    = isi_out_q;
  assign isi_valid  = isi_valid_q;
  assign burst_flag = burst_flag_q;

endmodule
